// File: rtl/sram_port_arbiter_pkg.sv
// sram_port_arbiter_pkg: shared widths and response-owner encoding for the SRAM port arbiter.
package sram_port_arbiter_pkg;
  localparam int ADDR_W = 64;
  localparam int DATA_W = 64;
  localparam int STRB_W = 8;
  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_INST = 2'd1,
    OWN_DATA = 2'd2
  } own_e;
endpackage

// File: rtl/sram_port_arbiter_if.sv
// sram_port_arbiter_if: one requester's request/response bundle; master = pipeline stage, slave = arbiter.
interface sram_port_arbiter_if;
  import sram_port_arbiter_pkg::*;
  logic              en;
  logic [STRB_W-1:0] we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;
  logic              rvalid;
  logic              stall;
  modport master (output en, we, addr, wdata, input rdata, rvalid, stall);
  modport slave  (input en, we, addr, wdata, output rdata, rvalid, stall);
endinterface

// File: rtl/sram_arb_starve_cnt.sv
// sram_arb_starve_cnt: counts consecutive denied instruction cycles and forces an instruction win at the limit.
module sram_arb_starve_cnt #(
  parameter int STARVE_LIMIT = 3,
  parameter int CNT_W        = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_ireq,
  input  logic i_inst_gnt,
  output logic o_force_inst
);
  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);
  logic [CNT_W-1:0] r_cnt;
  // i_ireq is already masked by flush, so a flush clears the count too
  always_ff @(posedge clk) begin
    if (!rst_n) r_cnt <= '0;
    else r_cnt <= (i_ireq & ~i_inst_gnt) ? ((&r_cnt) ? r_cnt : r_cnt + 1'b1) : '0;
  end
  assign o_force_inst = r_cnt >= LIMIT;
endmodule

// File: rtl/sram_port_arbiter.sv
// sram_port_arbiter: shares one SRAM port between instruction and data requesters, data-first priority.
// Define SRAM_ARB_STARVE_EN to add the instruction starvation guard.
module sram_port_arbiter
  import sram_port_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = 3,
  parameter int CNT_W        = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_flush,
  sram_port_arbiter_if.slave  inst_if,
  sram_port_arbiter_if.slave  data_if,
  output logic                o_sram_en,
  output logic [STRB_W-1:0]   o_sram_we,
  output logic [ADDR_W-1:0]   o_sram_addr,
  output logic [DATA_W-1:0]   o_sram_wdata,
  input  logic [DATA_W-1:0]   i_sram_rdata
);
  if (STARVE_LIMIT > (1 << CNT_W) - 1) begin : g_bad_cfg
    $error("STARVE_LIMIT does not fit in CNT_W bits");
  end
  logic w_ireq, w_dreq, w_inst_gnt, w_data_gnt, w_force_inst;
  own_e r_own, w_own_nxt;
  assign w_ireq = inst_if.en & ~i_flush & rst_n;
  assign w_dreq = data_if.en & rst_n;
`ifdef SRAM_ARB_STARVE_EN
  sram_arb_starve_cnt #(
    .STARVE_LIMIT (STARVE_LIMIT),
    .CNT_W        (CNT_W)
  ) u_starve (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_ireq       (w_ireq),
    .i_inst_gnt   (w_inst_gnt),
    .o_force_inst (w_force_inst)
  );
`else
  assign w_force_inst = 1'b0;
`endif
  assign w_inst_gnt = w_ireq & (~w_dreq | w_force_inst);
  assign w_data_gnt = w_dreq & ~w_inst_gnt;
  always_comb begin
    o_sram_en    = w_inst_gnt | w_data_gnt;
    o_sram_we    = w_inst_gnt ? inst_if.we    : w_data_gnt ? data_if.we    : '0;
    o_sram_addr  = w_inst_gnt ? inst_if.addr  : w_data_gnt ? data_if.addr  : '0;
    o_sram_wdata = w_inst_gnt ? inst_if.wdata : w_data_gnt ? data_if.wdata : '0;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) r_own <= OWN_NONE;
    else r_own <= w_own_nxt;
  end
  // writes never return data, so only read grants claim the response slot
  always_comb begin
    w_own_nxt = (w_inst_gnt & ~|inst_if.we) ? OWN_INST :
                (w_data_gnt & ~|data_if.we) ? OWN_DATA : OWN_NONE;
  end
  always_comb begin
    inst_if.rvalid = (r_own == OWN_INST) & ~i_flush & rst_n;
    data_if.rvalid = (r_own == OWN_DATA) & rst_n;
    inst_if.rdata  = i_sram_rdata;
    data_if.rdata  = i_sram_rdata;
    inst_if.stall  = w_ireq & ~w_inst_gnt;
    data_if.stall  = w_dreq & ~w_data_gnt;
  end
endmodule
